w_backward_arbiter: RTL and testbench

Merges the write-response (B) channels of four slave ports into one 14-bit response stream using round-robin arbitration. The merged stream feeds the per-master ID-bank response filters directly downstream; those filters key on DATAo[13:6] (ID) and pass DATAo[5:0] unchanged. The output is registered, giving one cycle of latency and full throughput with correct backpressure.

---
 rtl/w_backward_arbiter.sv | 99 +++++++++
 tb/tb_w_backward_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/w_backward_arbiter.sv
// ============================================================================
// Module   : w_backward_arbiter
// Brief    : Round-robin merge of four B-channel responses into one
//            registered 14-bit stream.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module w_backward_arbiter (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [13:0] DATA0,
    input  logic [13:0] DATA1,
    input  logic [13:0] DATA2,
    input  logic [13:0] DATA3,
    input  logic        VALID0,
    input  logic        VALID1,
    input  logic        VALID2,
    input  logic        VALID3,
    output logic        READY0,
    output logic        READY1,
    output logic        READY2,
    output logic        READY3,
    output logic [13:0] DATAo,
    output logic        VALIDo,
    input  logic        READYo
);

    logic [13:0] r_data;
    logic        r_valid;
    logic [1:0]  r_ptr;

    logic [3:0]  w_valid;
    logic [1:0]  w_idx;
    logic [1:0]  w_win;
    logic        w_found;
    logic        w_load;
    logic        w_grant;
    logic [3:0]  w_ready;
    logic [13:0] w_win_data;

    assign w_valid = {VALID3, VALID2, VALID1, VALID0};

    // First valid slave starting from the priority pointer, wrapping mod 4.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && w_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Held in reset, the register cannot take a beat, so no slave is acknowledged.
    assign w_load  = (~r_valid | READYo) & ARESETn;
    assign w_grant = w_load & w_found;
    assign w_ready = w_grant ? (4'b0001 << w_win) : 4'b0000;

    assign READY0 = w_ready[0];
    assign READY1 = w_ready[1];
    assign READY2 = w_ready[2];
    assign READY3 = w_ready[3];

    always_comb begin
        w_win_data = DATA0;
        case (w_win)
            2'd0:    w_win_data = DATA0;
            2'd1:    w_win_data = DATA1;
            2'd2:    w_win_data = DATA2;
            default: w_win_data = DATA3;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_data  <= 14'h0000;
            r_valid <= 1'b0;
            r_ptr   <= 2'd0;
        end else if (w_load) begin
            if (w_found) begin
                r_data  <= w_win_data;
                r_valid <= 1'b1;
                r_ptr   <= w_win + 2'd1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign DATAo  = r_data;
    assign VALIDo = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_w_backward_arbiter.sv
// ============================================================================
// Module   : tb_w_backward_arbiter
// Brief    : Directed self-checking bench for w_backward_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_w_backward_arbiter;

    logic        clk;
    logic        rst_n;
    logic [13:0] data [4];
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [13:0] data_o;
    logic        valid_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    w_backward_arbiter dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .DATA0   (data[0]),
        .DATA1   (data[1]),
        .DATA2   (data[2]),
        .DATA3   (data[3]),
        .VALID0  (valid[0]),
        .VALID1  (valid[1]),
        .VALID2  (valid[2]),
        .VALID3  (valid[3]),
        .READY0  (ready[0]),
        .READY1  (ready[1]),
        .READY2  (ready[2]),
        .READY3  (ready[3]),
        .DATAo   (data_o),
        .VALIDo  (valid_o),
        .READYo  (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        ready_o = 1'b1;
        valid   = 4'b1111;
        for (int x = 0; x < 4; x++) data[x] = {8'hA0 + 8'(x), 6'(x)};
        step();
        step();
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
        checks++;
        if (data_o !== 14'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", data_o); end
        checks++;
        if (ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", ready); end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_rotation();
        logic [13:0] exp_seq [5];
        exp_seq[0] = 14'h2800; exp_seq[1] = 14'h2841; exp_seq[2] = 14'h2882;
        exp_seq[3] = 14'h28C3; exp_seq[4] = 14'h2800;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (ready !== (4'b0001 << (k % 4)))
                begin errors++; $display("FAIL rot_ready[%0d] got %b exp %b", k, ready, 4'b0001 << (k % 4)); end
            step();
            checks++;
            if (valid_o !== 1'b1 || data_o !== exp_seq[k])
                begin errors++; $display("FAIL rot_data[%0d] got %b/%h exp 1/%h", k, valid_o, data_o, exp_seq[k]); end
        end
    endtask

    task automatic test_backpressure();
        // pointer is 1 here; slave 0 is the only requester so it still wins
        valid   = 4'b0001;
        data[0] = 14'h1234;
        step();
        ready_o = 1'b0;
        valid   = 4'b0100;
        data[2] = 14'h2ABC;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (ready !== 4'b0000 || valid_o !== 1'b1 || data_o !== 14'h1234)
                begin errors++; $display("FAIL stall[%0d] got ready %b v %b d %h exp 0000/1/1234", k, ready, valid_o, data_o); end
            step();
        end
        ready_o = 1'b1;
        #1;
        checks++;
        if (ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b exp 0100", ready); end
        step();
        checks++;
        if (valid_o !== 1'b1 || data_o !== 14'h2ABC)
            begin errors++; $display("FAIL bp_data got %b/%h exp 1/2abc", valid_o, data_o); end
    endtask

    task automatic test_skip_wrap();
        // pointer is 3 after slave 2 won
        valid   = 4'b0010;
        data[1] = 14'h0111;
        #1;
        checks++;
        if (ready !== 4'b0010) begin errors++; $display("FAIL skip_ready got %b exp 0010", ready); end
        step();
        checks++;
        if (data_o !== 14'h0111) begin errors++; $display("FAIL skip_data got %h exp 0111", data_o); end
        valid   = 4'b1001;
        data[0] = 14'h0200;
        data[3] = 14'h0333;
        #1;
        checks++;
        if (ready !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b exp 1000", ready); end
        step();
        checks++;
        if (data_o !== 14'h0333) begin errors++; $display("FAIL wrap_data3 got %h exp 0333", data_o); end
        checks++;
        if (ready !== 4'b0001) begin errors++; $display("FAIL wrap_second got %b exp 0001", ready); end
        step();
        checks++;
        if (data_o !== 14'h0200) begin errors++; $display("FAIL wrap_data0 got %h exp 0200", data_o); end
        valid = 4'b0000;
        step();
    endtask

    task automatic test_idle_drain();
        valid   = 4'b0100;
        data[2] = 14'h0155;
        #1;
        checks++;
        if (ready !== 4'b0100) begin errors++; $display("FAIL drain_ready got %b exp 0100", ready); end
        step();
        valid = 4'b0000;
        checks++;
        if (valid_o !== 1'b1 || data_o !== 14'h0155)
            begin errors++; $display("FAIL drain_beat got %b/%h exp 1/0155", valid_o, data_o); end
        step();
        checks++;
        if (valid_o !== 1'b0 || data_o !== 14'h0155)
            begin errors++; $display("FAIL drain_idle got %b/%h exp 0/0155", valid_o, data_o); end
        step();
        checks++;
        if (valid_o !== 1'b0 || ready !== 4'b0000)
            begin errors++; $display("FAIL drain_idle2 got %b/%b exp 0/0000", valid_o, ready); end
    endtask

    task automatic test_async_reset();
        valid   = 4'b0001;
        data[0] = 14'h3FFF;
        ready_o = 1'b0;
        step();
        valid = 4'b0000;
        step();
        checks++;
        if (valid_o !== 1'b1 || data_o !== 14'h3FFF)
            begin errors++; $display("FAIL ar_stall got %b/%h exp 1/3fff", valid_o, data_o); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || data_o !== 14'h0000)
            begin errors++; $display("FAIL ar_immediate got %b/%h exp 0/0000", valid_o, data_o); end
        rst_n = 1'b1;
        #1;
        valid   = 4'b1001;
        data[0] = 14'h0A0A;
        data[3] = 14'h0B0B;
        ready_o = 1'b1;
        #1;
        checks++;
        if (ready !== 4'b0001) begin errors++; $display("FAIL ar_ptr0 got %b exp 0001", ready); end
        step();
        checks++;
        if (data_o !== 14'h0A0A || ready !== 4'b1000)
            begin errors++; $display("FAIL ar_first got %h/%b exp 0a0a/1000", data_o, ready); end
        step();
        checks++;
        if (data_o !== 14'h0B0B) begin errors++; $display("FAIL ar_second got %h exp 0b0b", data_o); end
        valid = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_backpressure();
        test_skip_wrap();
        test_idle_drain();
        test_async_reset();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
